// File: rtl/extended_alu_mc_if.sv
// Operand/result bus between the EX-stage pipeline controller and the
// multi-cycle extended ALU. The controller is the master.
interface extended_alu_mc_if;
   logic        start;
   logic [2:0]  func;
   logic [31:0] src1;
   logic [31:0] src0;
   logic        busy;
   logic        done;
   logic [31:0] dst_EX_DM;
   logic        ov;
   logic        zr;
   logic        neg;
   logic        div_by_zero;

   modport master (output start, func, src1, src0,
                   input  busy, done, dst_EX_DM, ov, zr, neg, div_by_zero);
   modport slave  (input  start, func, src1, src0,
                   output busy, done, dst_EX_DM, ov, zr, neg, div_by_zero);
endinterface

// File: rtl/extended_alu_mc.sv
// Multi-cycle extended ALU for EX: single-cycle integer/FP ops plus a signed
// iterative divider, all feeding a common OUT_STAGES-deep result pipeline.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no divide active; any op may start
// S_RUN  | one restoring-division step per cycle, r_cnt DIV_W-1 .. 0
// S_FIX  | apply signs / special cases, inject result into stage 0
module extended_alu_mc #(
   parameter int OUT_STAGES = 1,
   parameter int DIV_W      = 32,
   parameter int MUL_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   extended_alu_mc_if.slave bus
);
   localparam logic [2:0] F_MUL  = 3'b000;
   localparam logic [2:0] F_UMUL = 3'b001;
   localparam logic [2:0] F_ADDF = 3'b010;
   localparam logic [2:0] F_SUBF = 3'b011;
   localparam logic [2:0] F_MULF = 3'b100;
   localparam logic [2:0] F_ITF  = 3'b101;
   localparam logic [2:0] F_FTI  = 3'b110;
   localparam logic [2:0] F_DIV  = 3'b111;
   localparam int         CNT_W  = $clog2(DIV_W);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   typedef struct packed {
      logic [31:0] data;
      logic        ov;
      logic        zr;
      logic        neg;
      logic        dbz;
   } res_t;

   // Single-precision add, truncating; denormal inputs are treated as zero.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] big, sml;
      logic [26:0] m_big, m_sml;
      logic [27:0] m_sum;
      int          d, e_res, lz;
      logic        found;
      if (a[30:23] == 8'h00) return b;
      if (b[30:23] == 8'h00) return a;
      if (a[30:0] >= b[30:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d     = int'(big[30:23]) - int'(sml[30:23]);
      e_res = int'(big[30:23]);
      m_big = {1'b1, big[22:0], 3'b000};
      m_sml = (d > 26) ? 27'h0 : ({1'b1, sml[22:0], 3'b000} >> d);
      if (big[31] == sml[31]) begin
         m_sum = {1'b0, m_big} + {1'b0, m_sml};
         if (m_sum[27]) begin
            m_sum = m_sum >> 1;
            e_res = e_res + 1;
         end
      end else begin
         m_sum = {1'b0, m_big} - {1'b0, m_sml};
         if (m_sum == '0) return 32'h0;
         lz    = 0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (m_sum[i]) found = 1'b1;
               else          lz    = lz + 1;
            end
         end
         m_sum = m_sum << lz;
         e_res = e_res - lz;
      end
      if (e_res <= 0)   return {big[31], 31'h0};
      if (e_res >= 255) return {big[31], 8'hFF, 23'h0};
      return {big[31], 8'(e_res), 23'(m_sum >> 3)};
   endfunction

   // Single-precision multiply, truncating; zero/denormal in gives signed zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
      p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) e = e + 1;
      else       p = p << 1;
      if (e <= 0)   return {s, 31'h0};
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, 8'(e), 23'(p >> 24)};
   endfunction

   function automatic logic [31:0] int_to_fp(input logic [31:0] x);
      logic [31:0] mag;
      int          msb;
      if (x == '0) return 32'h0;
      mag = x[31] ? -x : x;
      msb = 0;
      for (int i = 0; i < 32; i++) begin
         if (mag[i]) msb = i;
      end
      mag = mag << (31 - msb);
      return {x[31], 8'(127 + msb), 23'(mag >> 8)};
   endfunction

   // Truncates toward zero; out-of-range magnitudes saturate.
   function automatic logic [31:0] fp_to_int(input logic [31:0] f);
      logic [31:0] mag;
      int          e;
      e = int'(f[30:23]) - 127;
      if (e < 0)   return 32'h0;
      if (e >= 31) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      mag = {8'h0, 1'b1, f[22:0]};
      mag = (e >= 23) ? (mag << (e - 23)) : (mag >> (23 - e));
      return f[31] ? -mag : mag;
   endfunction

   function automatic logic [31:0] int_mul(input logic [MUL_W-1:0] a,
                                           input logic [MUL_W-1:0] b,
                                           input logic             sgn);
      logic [31:0] ax, bx;
      if (sgn) begin
         ax = 32'($signed(a));
         bx = 32'($signed(b));
      end else begin
         ax = 32'(a);
         bx = 32'(b);
      end
      return ax * bx;
   endfunction

   state_t                    r_state, w_state_nxt;
   logic                      r_busy;
   logic [CNT_W-1:0]          r_cnt;
   logic [DIV_W-1:0]          r_rem, r_quo, r_dvs;
   logic                      r_sa, r_sb;
   logic [OUT_STAGES-1:0]     r_vld;
   res_t                      r_pipe [OUT_STAGES];

   logic                      w_accept, w_div_go, w_in_vld;
   logic [DIV_W-1:0]          w_abs_a, w_abs_b;
   logic [DIV_W:0]            w_rem_sh, w_sub;
   logic                      w_q_neg;
   logic signed [DIV_W-1:0]   w_q_s;
   res_t                      w_res, w_div, w_in;

   assign w_accept = bus.start & ~r_busy;
   assign w_div_go = w_accept & (bus.func == F_DIV);
   assign w_in_vld = (r_state == S_FIX) | (w_accept & (bus.func != F_DIV));
   assign w_in     = (r_state == S_FIX) ? w_div : w_res;

   assign w_abs_a  = bus.src1[DIV_W-1] ? -bus.src1[DIV_W-1:0] : bus.src1[DIV_W-1:0];
   assign w_abs_b  = bus.src0[DIV_W-1] ? -bus.src0[DIV_W-1:0] : bus.src0[DIV_W-1:0];
   assign w_rem_sh = {r_rem, r_quo[DIV_W-1]};
   assign w_sub    = w_rem_sh - {1'b0, r_dvs};

   // Single-cycle ops computed straight from the bus so they land in stage 0 at the start edge.
   always_comb begin
      w_res = '0;
      case (bus.func)
         F_MUL:   w_res.data = int_mul(bus.src1[MUL_W-1:0], bus.src0[MUL_W-1:0], 1'b1);
         F_UMUL:  w_res.data = int_mul(bus.src1[MUL_W-1:0], bus.src0[MUL_W-1:0], 1'b0);
         F_ADDF:  w_res.data = fp_add(bus.src1, bus.src0);
         F_SUBF:  w_res.data = fp_add(bus.src1, {~bus.src0[31], bus.src0[30:0]});
         F_MULF:  w_res.data = fp_mul(bus.src1, bus.src0);
         F_ITF:   w_res.data = int_to_fp(bus.src1);
         F_FTI:   w_res.data = fp_to_int(bus.src1);
         default: w_res.data = 32'h0;
      endcase
      case (bus.func)
         F_ADDF, F_SUBF, F_MULF, F_ITF: w_res.zr = ~|w_res.data[30:0];
         default:                       w_res.zr = ~|w_res.data;
      endcase
      w_res.neg = (bus.func == F_UMUL) ? 1'b0 : w_res.data[31];
   end

   // Divide fix-up: sign application and the zero-divisor / overflow saturations.
   always_comb begin
      w_div    = '0;
      w_q_neg  = r_sa ^ r_sb;
      w_q_s    = w_q_neg ? -r_quo : r_quo;
      w_div.data = 32'(w_q_s);
      if (r_dvs == '0) begin
         w_div.data = r_sa ? 32'h8000_0000 : 32'h7FFF_FFFF;
         w_div.ov   = 1'b1;
         w_div.dbz  = 1'b1;
      end else if (!w_q_neg && r_quo[DIV_W-1]) begin
         w_div.data = 32'({1'b0, {(DIV_W-1){1'b1}}});
         w_div.ov   = 1'b1;
      end
      w_div.zr  = ~|w_div.data;
      w_div.neg = w_div.data[31];
   end

   // Divider FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Divider FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_div_go) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Divider datapath and busy: busy spans RUN and FIX so nothing can start on the injection cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_div_go) begin
                  r_busy <= 1'b1;
                  r_cnt  <= CNT_W'(DIV_W - 1);
                  r_rem  <= '0;
                  r_quo  <= w_abs_a;
                  r_dvs  <= w_abs_b;
                  r_sa   <= bus.src1[DIV_W-1];
                  r_sb   <= bus.src0[DIV_W-1];
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt - 1'b1;
               if (!w_sub[DIV_W]) begin
                  r_rem <= w_sub[DIV_W-1:0];
                  r_quo <= {r_quo[DIV_W-2:0], 1'b1};
               end else begin
                  r_rem <= w_rem_sh[DIV_W-1:0];
                  r_quo <= {r_quo[DIV_W-2:0], 1'b0};
               end
            end
            S_FIX:   r_busy <= 1'b0;
            default: r_busy <= 1'b0;
         endcase
      end
   end

   // Result pipeline: valid bits always shift, payloads load only with valid so the outputs hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int k = 0; k < OUT_STAGES; k++) r_pipe[k] <= '0;
      end else begin
         r_vld[0] <= w_in_vld;
         if (w_in_vld) r_pipe[0] <= w_in;
         for (int k = 1; k < OUT_STAGES; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) r_pipe[k] <= r_pipe[k-1];
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_vld[OUT_STAGES-1];
   assign bus.dst_EX_DM   = r_pipe[OUT_STAGES-1].data;
   assign bus.ov          = r_pipe[OUT_STAGES-1].ov;
   assign bus.zr          = r_pipe[OUT_STAGES-1].zr;
   assign bus.neg         = r_pipe[OUT_STAGES-1].neg;
   assign bus.div_by_zero = r_pipe[OUT_STAGES-1].dbz;
endmodule

// File: tb/tb_extended_alu_mc.sv
// Bench for extended_alu_mc: vector table through a cycle-exact scoreboard,
// plus hand sequences for divide busy window, dropped starts and mid-divide reset.
module tb_extended_alu_mc;
   localparam int OUT_STAGES = 1;
   localparam int DIV_W      = 32;
   localparam int MUL_W      = 16;
   localparam int NV         = 20;

   localparam logic [2:0] F_MUL  = 3'b000;
   localparam logic [2:0] F_UMUL = 3'b001;
   localparam logic [2:0] F_ADDF = 3'b010;
   localparam logic [2:0] F_SUBF = 3'b011;
   localparam logic [2:0] F_MULF = 3'b100;
   localparam logic [2:0] F_ITF  = 3'b101;
   localparam logic [2:0] F_FTI  = 3'b110;
   localparam logic [2:0] F_DIV  = 3'b111;

   typedef struct packed {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ov;
      logic        zr;
      logic        neg;
      logic        dbz;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        ov;
      logic        zr;
      logic        neg;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   done_seen = 0;
   exp_t sb [$];
   vec_t vecs [NV];

   extended_alu_mc_if bus ();

   extended_alu_mc #(.OUT_STAGES(OUT_STAGES), .DIV_W(DIV_W), .MUL_W(MUL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic issue(input int id, input vec_t v, input bit accept);
      exp_t e;
      bus.start = 1'b1;
      bus.func  = v.func;
      bus.src1  = v.a;
      bus.src0  = v.b;
      if (accept) begin
         e.id  = id;
         e.res = v.res;
         e.ov  = v.ov;
         e.zr  = v.zr;
         e.neg = v.neg;
         e.dbz = v.dbz;
         e.cyc = cyc + ((v.func == F_DIV) ? (DIV_W + 1 + OUT_STAGES) : OUT_STAGES);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_not_busy(input string name);
      int n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy !== 1'b0) chk(name, 32'(bus.busy), 32'h0);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) chk(name, 32'(sb.size()), 32'h0);
   endtask

   // Scoreboard monitor: every done must match the oldest expectation, at its exact cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            done_seen++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'h1, 32'h0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("id%0d_data", e.id), bus.dst_EX_DM, e.res);
               chk($sformatf("id%0d_ov", e.id),   32'(bus.ov), 32'(e.ov));
               chk($sformatf("id%0d_zr", e.id),   32'(bus.zr), 32'(e.zr));
               chk($sformatf("id%0d_neg", e.id),  32'(bus.neg), 32'(e.neg));
               chk($sformatf("id%0d_dbz", e.id),  32'(bus.div_by_zero), 32'(e.dbz));
               chk($sformatf("id%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   c0;
      int   d0;
      vec_t v;

      //            func    a             b             res           ov    zr    neg   dbz
      vecs[0]  = '{F_ADDF, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{F_SUBF, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{F_MULF, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{F_UMUL, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{F_MUL,  32'h0000FFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{F_FTI,  32'h00000000, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{F_ITF,  32'hFFFFFFF9, 32'h00000000, 32'hC0E00000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{F_FTI,  32'hC0E00000, 32'h00000000, 32'hFFFFFFF9, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{F_MUL,  32'h12348003, 32'hABCD0002, 32'hFFFF0006, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{F_MULF, 32'h80000000, 32'h40400000, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{F_ITF,  32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{F_ADDF, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{F_DIV,  32'd100,      32'd7,        32'h0000000E, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{F_DIV,  32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{F_DIV,  32'd5,        32'd0,        32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{F_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{F_DIV,  32'd0,        32'd5,        32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{F_DIV,  32'hFFFFFFFB, 32'd0,        32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[19] = '{F_SUBF, 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0};

      bus.start = 1'b0;
      bus.func  = 3'b000;
      bus.src1  = 32'h0;
      bus.src0  = 32'h0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_dst",  bus.dst_EX_DM, 32'h0);
      chk("rst_flags", {28'h0, bus.ov, bus.zr, bus.neg, bus.div_by_zero}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         issue(i, vecs[i], 1'b1);
         if (vecs[i].func == F_DIV) wait_not_busy($sformatf("v%0d_busy_timeout", i));
      end
      wait_drain("table_drain");

      // Busy window and dropped starts: one during RUN, one on the FIX cycle.
      v  = '{F_DIV, 32'd100, 32'd7, 32'h0000000E, 1'b0, 1'b0, 1'b0, 1'b0};
      c0 = cyc;
      issue(100, v, 1'b1);
      chk("div_busy_first", 32'(bus.busy), 32'h1);
      repeat (4) @(negedge clk);
      issue(101, vecs[0], 1'b0);
      while (cyc < c0 + DIV_W + 1) @(negedge clk);
      chk("div_busy_fix", 32'(bus.busy), 32'h1);
      issue(102, vecs[3], 1'b0);
      chk("div_busy_clear", 32'(bus.busy), 32'h0);
      wait_drain("busy_seq_drain");
      repeat (3) @(negedge clk);

      // Reset ten cycles into a divide: abort with no done, outputs cleared.
      v  = '{F_DIV, 32'd1000, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      c0 = cyc;
      issue(200, v, 1'b0);
      while (cyc < c0 + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 32'h0);
      chk("midrst_dst",  bus.dst_EX_DM, 32'h0);
      d0 = done_seen;
      repeat (40) @(negedge clk);
      chk("midrst_no_done", 32'(done_seen - d0), 32'h0);

      v = '{F_DIV, 32'd9, 32'd3, 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0};
      issue(201, v, 1'b1);
      wait_not_busy("post_rst_busy_timeout");
      wait_drain("post_rst_drain");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
